// File: rtl/periph_timer.sv
// rtl/periph_timer.sv - prescaled 32-bit match timer behind a one-cycle request/ready register port.
// Optional define PERIPH_TIMER_IRQ_EN adds the CTRL.IRQ_EN bit and drives irq_o from MATCH.
module periph_timer #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  p_req_i,
    input  logic [ADDR_WIDTH-1:0] p_addr_i,
    input  logic                  p_wen_i,
    input  logic [31:0]           p_wdata_i,
    input  logic [3:0]            p_be_i,
    output logic [31:0]           p_rdata_o,
    output logic                  p_ready_o,
    output logic                  irq_o
);

`ifdef PERIPH_TIMER_IRQ_EN
    localparam logic [2:0] CTRL_MASK = 3'b111;
`else
    localparam logic [2:0] CTRL_MASK = 3'b101;
`endif

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    logic        r_ready;
    logic [31:0] r_rdata;
    logic [2:0]  r_ctrl;
    logic [15:0] r_prescale;
    logic [15:0] r_pcnt;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_match;

    logic        w_accept;
    logic        w_wr;
    logic [2:0]  w_off;
    logic        w_tick;
    logic        w_hit;
    logic        w_ctrl_wr;
    logic        w_w1c;
    logic [31:0] w_rd_mux;
    logic        w_addr_unused;

    assign w_accept      = p_req_i & ~r_ready;
    assign w_wr          = w_accept & p_wen_i;
    assign w_off         = p_addr_i[2:0];
    assign w_tick        = r_ctrl[0] & (r_pcnt == r_prescale);
    assign w_hit         = w_tick & (r_count == r_compare);
    assign w_ctrl_wr     = w_wr & (w_off == 3'd0) & p_be_i[0];
    assign w_w1c         = w_wr & (w_off == 3'd4) & p_be_i[0] & p_wdata_i[0];
    assign w_addr_unused = &{1'b0, p_addr_i};

    always_comb begin
        w_rd_mux = '0;
        case (w_off)
            3'd0:    w_rd_mux = {29'd0, r_ctrl};
            3'd1:    w_rd_mux = {16'd0, r_prescale};
            3'd2:    w_rd_mux = r_count;
            3'd3:    w_rd_mux = r_compare;
            3'd4:    w_rd_mux = {31'd0, r_match};
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ready    <= 1'b0;
            r_rdata    <= '0;
            r_ctrl     <= '0;
            r_prescale <= '0;
            r_pcnt     <= '0;
            r_count    <= '0;
            r_compare  <= '0;
            r_match    <= 1'b0;
        end else begin
            r_ready <= w_accept;
            r_rdata <= (w_accept && !p_wen_i) ? w_rd_mux : 32'd0;

            // Disabling the timer restarts the prescaler so re-enabling gives a full first period.
            if (w_ctrl_wr && !p_wdata_i[0])
                r_pcnt <= '0;
            else if (w_tick)
                r_pcnt <= '0;
            else if (r_ctrl[0])
                r_pcnt <= r_pcnt + 16'd1;

            if (w_ctrl_wr)
                r_ctrl <= p_wdata_i[2:0] & CTRL_MASK;

            if (w_wr && w_off == 3'd1)
                r_prescale <= {p_be_i[1] ? p_wdata_i[15:8] : r_prescale[15:8],
                               p_be_i[0] ? p_wdata_i[7:0]  : r_prescale[7:0]};

            if (w_wr && w_off == 3'd2)
                r_count <= be_merge(r_count, p_wdata_i, p_be_i);
            else if (w_tick)
                r_count <= (w_hit && r_ctrl[2]) ? 32'd0 : r_count + 32'd1;

            if (w_wr && w_off == 3'd3)
                r_compare <= be_merge(r_compare, p_wdata_i, p_be_i);

            if (w_hit)
                r_match <= 1'b1;
            else if (w_w1c)
                r_match <= 1'b0;
        end
    end

    assign p_ready_o = r_ready & ~rst_i;
    assign p_rdata_o = rst_i ? 32'd0 : r_rdata;

`ifdef PERIPH_TIMER_IRQ_EN
    assign irq_o = r_match & r_ctrl[1];
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_periph_timer.sv
// tb/tb_periph_timer.sv - randomized and directed bench for periph_timer against a cycle-level model.
module tb_periph_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p_req = 1'b0;
    logic [7:0]  p_addr = '0;
    logic        p_wen = 1'b0;
    logic [31:0] p_wdata = '0;
    logic [3:0]  p_be = '0;
    logic [31:0] p_rdata;
    logic        p_ready;
    logic        irq;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    periph_timer #(.ADDR_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .p_req_i(p_req), .p_addr_i(p_addr),
        .p_wen_i(p_wen), .p_wdata_i(p_wdata), .p_be_i(p_be),
        .p_rdata_o(p_rdata), .p_ready_o(p_ready), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

`ifdef PERIPH_TIMER_IRQ_EN
    localparam bit IRQ_BUILT = 1'b1;
`else
    localparam bit IRQ_BUILT = 1'b0;
`endif

    // Reference model: register file plus prescale count as plain integers.
    logic [2:0]  m_ctrl = '0;
    logic [15:0] m_pre = '0;
    int          m_pcnt = 0;
    logic [31:0] m_count = '0, m_cmp = '0;
    logic        m_match = 1'b0;
    logic        m_ready = 1'b0;
    logic [31:0] m_rdata = '0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (o & ~mask) | (w & mask);
    endfunction

    function automatic logic [31:0] model_read(input int off);
        case (off)
            0: return {29'd0, m_ctrl};
            1: return {16'd0, m_pre};
            2: return m_count;
            3: return m_cmp;
            4: return {31'd0, m_match};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit acc, tick, hit;
        int off, n_pcnt;
        logic [31:0] n_count, rd, tmp;
        if (rst) begin
            m_ctrl = '0; m_pre = '0; m_pcnt = 0; m_count = '0; m_cmp = '0;
            m_match = 1'b0; m_ready = 1'b0; m_rdata = '0;
        end else begin
            acc     = p_req && !m_ready;
            off     = int'(p_addr[2:0]);
            tick    = m_ctrl[0] && (m_pcnt == int'(m_pre));
            hit     = tick && (m_count == m_cmp);
            rd      = model_read(off);
            n_count = m_count;
            n_pcnt  = m_pcnt;
            if (tick) begin
                n_pcnt  = 0;
                n_count = (hit && m_ctrl[2]) ? 32'd0 : 32'((64'(m_count) + 64'd1) % 64'h1_0000_0000);
            end else if (m_ctrl[0]) begin
                n_pcnt = (m_pcnt + 1) % 65536;
            end
            if (hit) m_match = 1'b1;
            if (acc && p_wen) begin
                case (off)
                    0: if (p_be[0]) begin
                           m_ctrl = p_wdata[2:0] & (IRQ_BUILT ? 3'b111 : 3'b101);
                           if (!p_wdata[0]) n_pcnt = 0;
                       end
                    1: begin tmp = merge({16'd0, m_pre}, p_wdata, p_be); m_pre = tmp[15:0]; end
                    2: n_count = merge(m_count, p_wdata, p_be);
                    3: m_cmp = merge(m_cmp, p_wdata, p_be);
                    4: if (p_be[0] && p_wdata[0] && !hit) m_match = 1'b0;
                    default: ;
                endcase
            end
            m_count = n_count;
            m_pcnt  = n_pcnt;
            m_ready = acc;
            m_rdata = (acc && !p_wen) ? rd : 32'd0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", {31'd0, p_ready}, {31'd0, m_ready && !rst});
            check("rdata", p_rdata, (m_ready && !rst) ? m_rdata : 32'd0);
            check("irq", {31'd0, irq}, {31'd0, IRQ_BUILT && m_match && m_ctrl[1]});
        end
    end

    // Called and returns at posedge+1 with no access in flight.
    task automatic bus(input bit wen, input int off, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd);
        logic [4:0] hi;
        hi      = 5'($urandom);
        p_req   = 1'b1;
        p_wen   = wen;
        p_addr  = {hi, 3'(off)};
        p_wdata = wd;
        p_be    = be;
        @(posedge clk);
        @(negedge clk);
        rd = p_rdata;
        @(posedge clk);
        #1;
        p_req = 1'b0;
        p_wen = 1'b0;
    endtask

    task automatic wr(input int off, input logic [31:0] wd);
        logic [31:0] dummy;
        bus(1'b1, off, wd, 4'hF, dummy);
    endtask

    initial begin
        logic [31:0] rd;
        bit seen;
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        bit seen;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        for (int o = 0; o < 8; o++) begin
            bus(1'b0, o, 32'd0, 4'h0, rd);
            check($sformatf("reset_read_%0d", o), rd, 32'd0);
        end

        wr(3, 32'd0);
        bus(1'b1, 3, 32'hAABBCCDD, 4'b0010, rd);
        bus(1'b0, 3, 32'd0, 4'h0, rd);
        check("byte_write_compare", rd, 32'h0000CC00);

        wr(0, 0); wr(1, 0); wr(3, 5); wr(2, 32'hFFFFFFFF); wr(4, 1); wr(0, 1);
        bus(1'b0, 2, 0, 0, rd);
        check("count_wrap", rd, 32'd0);
        bus(1'b0, 4, 0, 0, rd);
        check("wrap_no_match", rd, 32'd0);

        wr(0, 0); wr(2, 0); wr(3, 3); wr(1, 1); wr(4, 1); wr(0, 5);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            bus(1'b0, 4, 0, 0, rd);
            seen = rd[0];
        end
        check("autoclr_match_seen", {31'd0, seen}, 32'd1);
        bus(1'b0, 2, 0, 0, rd);
        wr(0, 7);
        check("irq_after_irq_en", {31'd0, irq}, {31'd0, IRQ_BUILT});
        wr(4, 1); wr(0, 0);

        wr(0, 0); wr(1, 0); wr(3, 5); wr(2, 0); wr(4, 1); wr(0, 3);
        repeat (4) @(posedge clk);
        #1;
        wr(4, 1);
        bus(1'b0, 4, 0, 0, rd);
        check("match_beats_w1c", rd, 32'd1);
        check("irq_on_match", {31'd0, irq}, {31'd0, IRQ_BUILT});
        wr(4, 1);
        check("irq_drop_after_w1c", {31'd0, irq}, 32'd0);
        bus(1'b0, 4, 0, 0, rd);
        check("w1c_clears", rd, 32'd0);
        wr(0, 0);

        p_req = 1'b1; p_wen = 1'b1; p_addr = 8'd2; p_wdata = 32'h10; p_be = 4'hF;
        @(posedge clk);
        #1;
        rst = 1'b1;
        p_req = 1'b0; p_wen = 1'b0;
        @(negedge clk);
        check("no_ready_in_reset", {31'd0, p_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus(1'b0, 2, 0, 0, rd);
        check("count_after_reset", rd, 32'd0);

        for (int n = 0; n < 300; n++) begin
            int off;
            logic [31:0] wd;
            off = $urandom_range(0, 7);
            case ($urandom_range(0, 3))
                0:       wd = $urandom;
                1:       wd = 32'($urandom_range(0, 3));
                default: wd = 32'($urandom_range(0, 12));
            endcase
            bus(1'($urandom_range(0, 1)), off, wd, 4'($urandom), rd);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
